demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_stream_if.sv | 32 +++
 rtl/demux_stream.sv | 154 +++++++++++++++
 tb/tb_demux_stream.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/demux_stream_if.sv
// demux_stream_if: stream bundle for a 1-to-2 demultiplexer.
//   in_data/in_sel/in_valid/in_ready   : upstream word, destination select, handshake
//   outN_data/outN_valid/outN_ready    : per-port buffered word and handshake (N = 1, 2)
//   outN_count                         : words delivered on port N, modulo 2^16
// master : the environment side (drives upstream word and downstream ready)
// slave  : the demux side
interface demux_stream_if;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_count;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [15:0] out2_count;

    modport master (
        output in_data, in_sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out1_count,
               out2_data, out2_valid, out2_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out1_count,
               out2_data, out2_valid, out2_count
    );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: routes each upstream word to one of two output ports, each
// backed by a one-entry buffer (EMPTY/FULL), with a delivered-word counter
// per port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_stream_if.slave (upstream input, two buffered outputs)
// in_sel = 1 routes to port 1, in_sel = 0 routes to port 2.
module demux_stream (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_stream_if.slave        bus
);

    typedef enum logic {
        EMPTY_S = 1'b0,
        FULL_S  = 1'b1
    } buf_state_e;

    buf_state_e  state1_r, state1_next_s;
    buf_state_e  state2_r, state2_next_s;
    logic [31:0] data1_r, data2_r;
    logic [15:0] count1_r, count2_r;
    logic        valid1_s, valid2_s;
    logic        in_ready_s;
    logic        in_xfer1_s, in_xfer2_s;
    logic        out_xfer1_s, out_xfer2_s;

    // Handshake decode: a buffer can take a word if it is empty or is
    // draining this same cycle; in_valid deliberately does not feed in_ready.
    always_comb begin
        in_ready_s  = 1'b0;
        out_xfer1_s = (state1_r == FULL_S) && bus.out1_ready;
        out_xfer2_s = (state2_r == FULL_S) && bus.out2_ready;
        if (bus.in_sel) begin
            in_ready_s = (state1_r == EMPTY_S) || bus.out1_ready;
        end else begin
            in_ready_s = (state2_r == EMPTY_S) || bus.out2_ready;
        end
        in_xfer1_s = bus.in_valid && in_ready_s && bus.in_sel;
        in_xfer2_s = bus.in_valid && in_ready_s && !bus.in_sel;
    end

    // Buffer state registers for both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1_r <= EMPTY_S;
            state2_r <= EMPTY_S;
        end else begin
            state1_r <= state1_next_s;
            state2_r <= state2_next_s;
        end
    end

    // Next-state logic for port 1 buffer; a refill wins over a drain.
    always_comb begin
        state1_next_s = state1_r;
        case (state1_r)
            EMPTY_S: begin
                if (in_xfer1_s) begin
                    state1_next_s = FULL_S;
                end else begin
                    state1_next_s = EMPTY_S;
                end
            end
            FULL_S: begin
                if (in_xfer1_s) begin
                    state1_next_s = FULL_S;
                end else if (out_xfer1_s) begin
                    state1_next_s = EMPTY_S;
                end else begin
                    state1_next_s = FULL_S;
                end
            end
            default: state1_next_s = EMPTY_S;
        endcase
    end

    // Next-state logic for port 2 buffer; a refill wins over a drain.
    always_comb begin
        state2_next_s = state2_r;
        case (state2_r)
            EMPTY_S: begin
                if (in_xfer2_s) begin
                    state2_next_s = FULL_S;
                end else begin
                    state2_next_s = EMPTY_S;
                end
            end
            FULL_S: begin
                if (in_xfer2_s) begin
                    state2_next_s = FULL_S;
                end else if (out_xfer2_s) begin
                    state2_next_s = EMPTY_S;
                end else begin
                    state2_next_s = FULL_S;
                end
            end
            default: state2_next_s = EMPTY_S;
        endcase
    end

    // Output decode: valid is a direct decode of the state register.
    always_comb begin
        valid1_s = 1'b0;
        valid2_s = 1'b0;
        case (state1_r)
            FULL_S:  valid1_s = 1'b1;
            default: valid1_s = 1'b0;
        endcase
        case (state2_r)
            FULL_S:  valid2_s = 1'b1;
            default: valid2_s = 1'b0;
        endcase
    end

    // Data buffers: load only on an input transfer to that port, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_r <= 32'h0000_0000;
            data2_r <= 32'h0000_0000;
        end else begin
            if (in_xfer1_s) begin
                data1_r <= bus.in_data;
            end
            if (in_xfer2_s) begin
                data2_r <= bus.in_data;
            end
        end
    end

    // Delivered-word counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count1_r <= 16'h0000;
            count2_r <= 16'h0000;
        end else begin
            if (out_xfer1_s) begin
                count1_r <= count1_r + 16'd1;
            end
            if (out_xfer2_s) begin
                count2_r <= count2_r + 16'd1;
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out1_data  = data1_r;
    assign bus.out1_valid = valid1_s;
    assign bus.out1_count = count1_r;
    assign bus.out2_data  = data2_r;
    assign bus.out2_valid = valid2_s;
    assign bus.out2_count = count2_r;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed self-checking bench for demux_stream.
// Inputs change at the falling edge; outputs are checked at the falling edge
// (plus a small settle delay for the combinational in_ready).
module tb_demux_stream;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    demux_stream_if bus_if ();

    demux_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.in_data = 32'h0; bus_if.in_sel = 1'b1; bus_if.in_valid = 1'b0;
        bus_if.out1_ready = 1'b0; bus_if.out2_ready = 1'b0;
        @(negedge clk); #1;
        tests_run++; if (bus_if.out1_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out1_valid got %b exp 0", bus_if.out1_valid); end
        tests_run++; if (bus_if.out2_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out2_valid got %b exp 0", bus_if.out2_valid); end
        tests_run++; if (bus_if.out1_data !== 32'h0) begin tests_failed++; $display("FAIL rst_out1_data got %h exp 0", bus_if.out1_data); end
        tests_run++; if (bus_if.out2_data !== 32'h0) begin tests_failed++; $display("FAIL rst_out2_data got %h exp 0", bus_if.out2_data); end
        tests_run++; if (bus_if.out1_count !== 16'h0 || bus_if.out2_count !== 16'h0) begin tests_failed++; $display("FAIL rst_counts got %h/%h exp 0/0", bus_if.out1_count, bus_if.out2_count); end
        tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready_sel1 got %b exp 1", bus_if.in_ready); end
        bus_if.in_sel = 1'b0; #1;
        tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready_sel0 got %b exp 1", bus_if.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b1; bus_if.in_data = 32'hDEADBEEF; bus_if.out1_ready = 1'b1;
        #1;
        tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out1_valid !== 1'b1 || bus_if.out1_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_out1 got v=%b d=%h exp v=1 d=deadbeef", bus_if.out1_valid, bus_if.out1_data); end
        tests_run++; if (bus_if.out2_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_out2_valid got %b exp 0", bus_if.out2_valid); end
        tests_run++; if (bus_if.out1_count !== 16'd0) begin tests_failed++; $display("FAIL basic_count_before got %0d exp 0", bus_if.out1_count); end
        tick();
        tests_run++; if (bus_if.out1_count !== 16'd1 || bus_if.out1_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_count_after got c=%0d v=%b exp c=1 v=0", bus_if.out1_count, bus_if.out1_valid); end
        // ready held high on an empty buffer must not count
        tick();
        tests_run++; if (bus_if.out1_count !== 16'd1) begin tests_failed++; $display("FAIL empty_ready_count got %0d exp 1", bus_if.out1_count); end
        bus_if.out1_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus_if.out2_ready = 1'b0;
        bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b0; bus_if.in_data = 32'h0000_00A1;
        tick();
        bus_if.in_data = 32'h0000_00A2; #1;
        tests_run++; if (bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready got %b exp 0", bus_if.in_ready); end
        tests_run++; if (bus_if.out2_data !== 32'h0000_00A1 || bus_if.out2_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_first got d=%h v=%b exp a1/1", bus_if.out2_data, bus_if.out2_valid); end
        tick();
        tests_run++; if (bus_if.out2_data !== 32'h0000_00A1 || bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_hold got d=%h r=%b exp a1/0", bus_if.out2_data, bus_if.in_ready); end
        bus_if.out2_ready = 1'b1; #1;
        tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out2_data !== 32'h0000_00A2 || bus_if.out2_valid !== 1'b1 || bus_if.out2_count !== 16'd1) begin tests_failed++; $display("FAIL stall_second got d=%h v=%b c=%0d exp a2/1/1", bus_if.out2_data, bus_if.out2_valid, bus_if.out2_count); end
        tick();
        tests_run++; if (bus_if.out2_count !== 16'd2 || bus_if.out2_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_count got c=%0d v=%b exp 2/0", bus_if.out2_count, bus_if.out2_valid); end
        bus_if.out2_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus_if.out1_ready = 1'b1; bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b1; bus_if.in_data = 32'd1;
        tick();
        for (int k = 2; k <= 6; k++) begin
            bus_if.in_data = k; #1;
            tests_run++; if (bus_if.in_ready !== 1'b1 || bus_if.out1_valid !== 1'b1 || bus_if.out1_data !== 32'(k - 1) || bus_if.out1_count !== 16'(k - 1)) begin
                tests_failed++; $display("FAIL b2b_step%0d got r=%b v=%b d=%0d c=%0d exp 1/1/%0d/%0d", k, bus_if.in_ready, bus_if.out1_valid, bus_if.out1_data, bus_if.out1_count, k - 1, k - 1);
            end
            tick();
        end
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out1_data !== 32'd6) begin tests_failed++; $display("FAIL b2b_last got %0d exp 6", bus_if.out1_data); end
        tick();
        tests_run++; if (bus_if.out1_count !== 16'd7 || bus_if.out1_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_count got c=%0d v=%b exp 7/0", bus_if.out1_count, bus_if.out1_valid); end
        bus_if.out1_ready = 1'b0;
    endtask

    task automatic test_cross_port();
        bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b1; bus_if.in_data = 32'd11;
        tick();
        #1;
        tests_run++; if (bus_if.in_ready !== 1'b0) begin tests_failed++; $display("FAIL cross_p1_blocked got %b exp 0", bus_if.in_ready); end
        bus_if.in_sel = 1'b0; bus_if.in_data = 32'd22; #1;
        tests_run++; if (bus_if.in_ready !== 1'b1) begin tests_failed++; $display("FAIL cross_in_ready got %b exp 1", bus_if.in_ready); end
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out2_valid !== 1'b1 || bus_if.out2_data !== 32'd22) begin tests_failed++; $display("FAIL cross_out2 got v=%b d=%0d exp 1/22", bus_if.out2_valid, bus_if.out2_data); end
        tests_run++; if (bus_if.out1_valid !== 1'b1 || bus_if.out1_data !== 32'd11) begin tests_failed++; $display("FAIL cross_out1_hold got v=%b d=%0d exp 1/11", bus_if.out1_valid, bus_if.out1_data); end
        bus_if.out2_ready = 1'b1;
        tick();
        tests_run++; if (bus_if.out2_count !== 16'd3 || bus_if.out2_valid !== 1'b0 || bus_if.out1_data !== 32'd11 || bus_if.out1_count !== 16'd7) begin
            tests_failed++; $display("FAIL cross_after got c2=%0d v2=%b d1=%0d c1=%0d exp 3/0/11/7", bus_if.out2_count, bus_if.out2_valid, bus_if.out1_data, bus_if.out1_count);
        end
        bus_if.out2_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b0; bus_if.in_data = 32'd33;
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out1_valid !== 1'b1 || bus_if.out2_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_both_full got %b/%b exp 1/1", bus_if.out1_valid, bus_if.out2_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (bus_if.out1_valid !== 1'b0 || bus_if.out2_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b/%b exp 0/0", bus_if.out1_valid, bus_if.out2_valid); end
        tests_run++; if (bus_if.out1_count !== 16'h0 || bus_if.out2_count !== 16'h0 || bus_if.out1_data !== 32'h0 || bus_if.out2_data !== 32'h0) begin
            tests_failed++; $display("FAIL mid_clear got c=%h/%h d=%h/%h exp zeros", bus_if.out1_count, bus_if.out2_count, bus_if.out1_data, bus_if.out2_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b1; bus_if.in_data = 32'd55;
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out1_valid !== 1'b1 || bus_if.out1_data !== 32'd55) begin tests_failed++; $display("FAIL first_after_rst got v=%b d=%0d exp 1/55", bus_if.out1_valid, bus_if.out1_data); end
    endtask

    task automatic test_wrap();
        // buffer 1 holds one word, count starts at 0
        bus_if.out1_ready = 1'b1; bus_if.in_valid = 1'b1; bus_if.in_sel = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus_if.in_data = i;
            tick();
        end
        tests_run++; if (bus_if.out1_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_pre got %h exp ffff", bus_if.out1_count); end
        tests_run++; if (bus_if.out1_data !== 32'd65534) begin tests_failed++; $display("FAIL wrap_order got %0d exp 65534", bus_if.out1_data); end
        bus_if.in_data = 32'hCAFE_0000;
        tick();
        bus_if.in_valid = 1'b0;
        tests_run++; if (bus_if.out1_count !== 16'h0000 || bus_if.out1_data !== 32'hCAFE_0000) begin tests_failed++; $display("FAIL wrap_post got c=%h d=%h exp 0000/cafe0000", bus_if.out1_count, bus_if.out1_data); end
        tick();
        tests_run++; if (bus_if.out1_count !== 16'h0001 || bus_if.out1_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_drain got c=%h v=%b exp 0001/0", bus_if.out1_count, bus_if.out1_valid); end
        bus_if.out1_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_cross_port();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
